// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   req0/1, we0/1, addr0/1, wdata0/1 : requester -> arbiter
//   ack0/1, rdata0/1, err0/1          : arbiter -> requester
//   mem_addr, mem_wdata, mem_re/we    : arbiter -> memory
//   mem_rdata                         : memory -> arbiter (combinational read)
//   stall, busy                       : arbiter status
// Modport slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if;
  logic               req0, req1;
  logic               we0, we1;
  logic        [63:0] addr0, addr1;
  logic signed [63:0] wdata0, wdata1;
  logic               ack0, ack1;
  logic signed [63:0] rdata0, rdata1;
  logic               err0, err1;
  logic        [63:0] mem_addr;
  logic        [63:0] mem_wdata;
  logic               mem_re, mem_we;
  logic        [63:0] mem_rdata;
  logic               stall, busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_re, mem_we, stall, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_re, mem_we, stall, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and fixed-latency sequencer for the single-port
// data memory. Port 0 is the pipeline MEM stage, port 1 the debug/loader.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_arbiter_if.slave (requests, responses, memory side, stall/busy)
//
//   state  | meaning
//   IDLE   | arbitrate; latch winner's request on a grant
//   ACCESS | drive memory for LATENCY cycles, capture result on the last one
//   RESP   | one-cycle ack to the winner
module dmem_arbiter #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        oor_q, oor_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic        sel1;
  logic [63:0] load_val;
  logic        ack0, ack1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    sel1     = 1'b0;
    load_val = '0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the port that was not served last wins.
          sel1    = bus.req1 && (!bus.req0 || !last_q);
          win_d   = sel1;
          last_d  = sel1;
          we_d    = sel1 ? bus.we1 : bus.we0;
          addr_d  = sel1 ? bus.addr1 : bus.addr0;
          wdata_d = sel1 ? bus.wdata1 : bus.wdata0;
          oor_d   = (sel1 ? bus.addr1 : bus.addr0) >= DEPTH_W;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          load_val = oor_q ? 64'd0 : bus.mem_rdata;
          // Stores only touch err; loads also replace rdata.
          if (!win_q) begin
            err0_d = oor_q;
            if (!we_q) rdata0_d = load_val;
          end else begin
            err1_d = oor_q;
            if (!we_q) rdata1_d = load_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    if (state_q == ACCESS) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_re    = !we_q && !oor_q;
      // A single write strobe at the end of the window.
      bus.mem_we    = we_q && !oor_q && (cnt_q == 4'd0);
    end
    ack0     = (state_q == RESP) && !win_q;
    ack1     = (state_q == RESP) && win_q;
    bus.busy = (state_q != IDLE);
  end

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.stall  = bus.req0 & ~ack0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (LATENCY = 3). A transaction-level
// model predicts every cycle's outputs from the grant time and the rules;
// directed tests add hand-computed literal checks.
module tb_dmem_arbiter;
  localparam int LAT = 3;

  logic clk;
  logic reset;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  bit chk_en = 1'b0;

  // memory seen by the DUT (indexes low bits only, so stray enables show up)
  logic [63:0] mem [0:1023];
  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[9:0]] : 64'h0;
  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_addr[9:0]] = bus.mem_wdata;

  function automatic logic [63:0] init_word(int i);
    return 64'(i) * 64'h101 + 64'h11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [63:0] mm [0:1023];
  bit          m_active, m_last, m_win, m_we;
  int          m_age;
  logic [63:0] m_addr, m_wdata;
  logic [63:0] e_rdata [2];
  bit          e_err [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_age = 0; m_last = 1'b1;
      e_rdata[0] = '0; e_rdata[1] = '0; e_err[0] = 1'b0; e_err[1] = 1'b0;
    end else if (m_active) begin
      m_age++;
      if (m_age == LAT + 1) begin
        if (m_addr >= 64'd1024) begin
          e_err[m_win] = 1'b1;
          if (!m_we) e_rdata[m_win] = '0;
        end else begin
          e_err[m_win] = 1'b0;
          if (m_we) mm[m_addr[9:0]] = m_wdata;
          else      e_rdata[m_win] = mm[m_addr[9:0]];
        end
      end else if (m_age == LAT + 2) begin
        m_active = 1'b0;
      end
    end else if (bus.req0 || bus.req1) begin
      m_win    = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_last   = m_win;
      m_we     = m_win ? bus.we1 : bus.we0;
      m_addr   = m_win ? bus.addr1 : bus.addr0;
      m_wdata  = m_win ? bus.wdata1 : bus.wdata0;
      m_active = 1'b1;
      m_age    = 1;
    end
  end

  always @(negedge clk) begin
    logic acc, rsp, inr;
    if (bus.mem_re) re_cnt++;
    if (bus.mem_we) we_cnt++;
    if (!reset && chk_en) begin
      acc = m_active && (m_age <= LAT);
      rsp = m_active && (m_age == LAT + 1);
      inr = m_addr < 64'd1024;
      check("busy",   64'(bus.busy),   64'(acc || rsp));
      check("ack0",   64'(bus.ack0),   64'(rsp && !m_win));
      check("ack1",   64'(bus.ack1),   64'(rsp && m_win));
      check("mem_re", 64'(bus.mem_re), 64'(acc && !m_we && inr));
      check("mem_we", 64'(bus.mem_we), 64'(acc && m_we && inr && m_age == LAT));
      if (acc) begin
        check("mem_addr",  bus.mem_addr, m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("stall",  64'(bus.stall),  64'(bus.req0 && !(rsp && !m_win)));
      check("rdata0", bus.rdata0, e_rdata[0]);
      check("rdata1", bus.rdata1, e_rdata[1]);
      check("err0",   64'(bus.err0),   64'(e_err[0]));
      check("err1",   64'(bus.err1),   64'(e_err[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int port, output int lat);
    lat = 0;
    repeat (30) begin
      @(posedge clk); #1;
      lat++;
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) return;
    end
    lat = -1;
  endtask

  // Issue one request, wait for its ack, drop req in the following cycle.
  task automatic do_txn(input int port, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, output int lat);
    if (port == 0) begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
    wait_ack(port, lat);
    @(posedge clk); #1;
    if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      64'(bus.busy), 64'd0);
    check({tag, " ack0"},      64'(bus.ack0), 64'd0);
    check({tag, " ack1"},      64'(bus.ack1), 64'd0);
    check({tag, " mem_re"},    64'(bus.mem_re), 64'd0);
    check({tag, " mem_we"},    64'(bus.mem_we), 64'd0);
    check({tag, " err0"},      64'(bus.err0), 64'd0);
    check({tag, " err1"},      64'(bus.err1), 64'd0);
    check({tag, " rdata0"},    bus.rdata0, 64'd0);
    check({tag, " rdata1"},    bus.rdata1, 64'd0);
    check({tag, " mem_addr"},  bus.mem_addr, 64'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    int got[$];
    int t_ack[$];
    int t;

    reset = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = init_word(i);
      mm[i]  = init_word(i);
    end
    mem[5] = 64'h2A;
    mm[5]  = 64'h2A;

    #2 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // single load on port 0
    re_cnt = 0;
    do_txn(0, 1'b0, 64'd5, 64'd0, lat);
    check("load0 ack latency", 64'(lat), 64'(LAT + 1));
    check("load0 rdata0", bus.rdata0, 64'd42);
    check("load0 err0", 64'(bus.err0), 64'd0);
    check("load0 mem_re cycles", 64'(re_cnt), 64'(LAT));

    // store -7 then load it back on port 1
    we_cnt = 0;
    do_txn(1, 1'b1, 64'd10, -64'sd7, lat);
    check("store1 ack latency", 64'(lat), 64'd4);
    check("store1 mem_we cycles", 64'(we_cnt), 64'd1);
    check("store1 mem[10]", mem[10], 64'hFFFF_FFFF_FFFF_FFF9);
    check("store1 rdata1 kept", bus.rdata1, 64'd0);
    do_txn(1, 1'b0, 64'd10, 64'd0, lat);
    check("load1 rdata1", bus.rdata1, 64'hFFFF_FFFF_FFFF_FFF9);
    check("load1 err1", 64'(bus.err1), 64'd0);

    // continuous contention from reset
    pulse_reset();
    bus.we0 = 1'b0; bus.addr0 = 64'd5;  bus.req0 = 1'b1;
    bus.we1 = 1'b0; bus.addr1 = 64'd10; bus.req1 = 1'b1;
    t = 0;
    while (got.size() < 4 && t < 60) begin
      @(posedge clk); #1;
      t++;
      if (bus.ack0) begin got.push_back(0); t_ack.push_back(t); end
      if (bus.ack1) begin got.push_back(1); t_ack.push_back(t); end
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contention grants", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++) begin
      check("contention order", 64'(got[i]), 64'(i % 2));
      check("contention ack time", 64'(t_ack[i]), 64'(4 + 5 * i));
    end
    check("contention rdata0", bus.rdata0, 64'd42);
    check("contention rdata1", bus.rdata1, 64'hFFFF_FFFF_FFFF_FFF9);

    // out-of-range load and store
    re_cnt = 0; we_cnt = 0;
    do_txn(0, 1'b0, 64'd1024, 64'd0, lat);
    check("oor load latency", 64'(lat), 64'(LAT + 1));
    check("oor load err0", 64'(bus.err0), 64'd1);
    check("oor load rdata0", bus.rdata0, 64'd0);
    do_txn(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, lat);
    check("oor store latency", 64'(lat), 64'(LAT + 1));
    check("oor store err1", 64'(bus.err1), 64'd1);
    check("oor store rdata1", bus.rdata1, 64'hFFFF_FFFF_FFFF_FFF9);
    check("oor mem_re cycles", 64'(re_cnt), 64'd0);
    check("oor mem_we cycles", 64'(we_cnt), 64'd0);
    check("oor mem[1023]", mem[1023], init_word(1023));
    check("oor mem[0]", mem[0], init_word(0));

    // reset in the 2nd ACCESS cycle of a store
    pulse_reset();
    we_cnt = 0;
    bus.we1 = 1'b1; bus.addr1 = 64'd20; bus.wdata1 = 64'h1234; bus.req1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset busy before", 64'(bus.busy), 64'd1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    bus.req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset mem_we cycles", 64'(we_cnt), 64'd0);
    check("midreset mem[20]", mem[20], init_word(20));
    bus.we0 = 1'b0; bus.addr0 = 64'd20; bus.req0 = 1'b1;
    bus.we1 = 1'b0; bus.addr1 = 64'd5;  bus.req1 = 1'b1;
    t = 0;
    while (!bus.ack0 && !bus.ack1 && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    check("post-reset tie ack0", 64'(bus.ack0), 64'd1);
    check("post-reset tie ack time", 64'(t), 64'(LAT + 1));
    check("post-reset rdata0", bus.rdata0, init_word(20));
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    wait_ack(1, lat);
    check("post-reset port1 wait", 64'(lat), 64'(LAT + 1));
    check("post-reset rdata1", bus.rdata1, 64'd42);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
